// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and interlock state encoding.
// Used by the load-use interlock and its instruction source decoder.
package riscv_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_DRAIN     = 2'd2
  } lui_state_e;

  // x0 is hardwired to zero, so it can never carry a real dependency.
  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return used && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/inst_src_decode.sv
// Opcode classifier: which register sources an instruction reads and
// whether it is a load.
module inst_src_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       is_load
);

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_IMM, OPC_JALR: rs1_used = 1'b1;
      OPC_LOAD: begin
        rs1_used = 1'b1;
        is_load  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_use_interlock.sv
// Load-use hazard interlock: tracks one outstanding load and stalls decode
// while a dependent instruction would read stale data.
module load_use_interlock
  import riscv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      D_inst,
  input  logic             D_valid,
  input  logic [31:0]      X_inst,
  input  logic             X_valid,
  input  logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  input  logic             flush,
  output logic             stall,
  output logic             pending,
  output logic [4:0]       pending_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             protocol_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lui_state_e       state_q, state_d;
  logic [4:0]       pending_rd_q, pending_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             protocol_err_q, protocol_err_d;

  logic       d_rs1_used, d_rs2_used, d_is_load;
  logic       x_rs1_used, x_rs2_used, x_is_load;
  logic [4:0] d_rs1, d_rs2, x_rd;
  logic       load_acc, haz_a, haz_b;
  logic       unused_sig;

  assign d_rs1 = D_inst[19:15];
  assign d_rs2 = D_inst[24:20];
  assign x_rd  = X_inst[11:7];

  assign unused_sig = ^{D_inst[31:25], D_inst[14:7], X_inst[31:12],
                        d_is_load, x_rs1_used, x_rs2_used};

  inst_src_decode u_dec_d (
    .opcode   (D_inst[6:0]),
    .rs1_used (d_rs1_used),
    .rs2_used (d_rs2_used),
    .is_load  (d_is_load)
  );

  inst_src_decode u_dec_x (
    .opcode   (X_inst[6:0]),
    .rs1_used (x_rs1_used),
    .rs2_used (x_rs2_used),
    .is_load  (x_is_load)
  );

  // A load is older than anything flush kills, but a flushed X never issues.
  assign load_acc = X_valid && x_is_load && (x_rd != 5'd0) &&
                    dmem_req_valid && dmem_req_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (load_acc) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: if (dmem_resp_valid) state_d = ST_DRAIN;
      ST_DRAIN:     state_d = load_acc ? ST_WAIT_RESP : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending = (state_q == ST_WAIT_RESP) || (state_q == ST_DRAIN);
    haz_a   = (state_q == ST_WAIT_RESP) &&
              (src_match(d_rs1_used, d_rs1, pending_rd_q) ||
               src_match(d_rs2_used, d_rs2, pending_rd_q));
    haz_b   = X_valid && x_is_load && (x_rd != 5'd0) &&
              (src_match(d_rs1_used, d_rs1, x_rd) ||
               src_match(d_rs2_used, d_rs2, x_rd));
    stall   = D_valid && !flush && (haz_a || haz_b);
  end

  // A second load during WAIT_RESP or a stray response is a memory-side bug.
  always_comb begin
    pending_rd_d = pending_rd_q;
    if (load_acc && (state_q != ST_WAIT_RESP)) pending_rd_d = x_rd;
    protocol_err_d = protocol_err_q ||
                     (load_acc && (state_q == ST_WAIT_RESP)) ||
                     (dmem_resp_valid && (state_q != ST_WAIT_RESP));
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_rd_q   <= 5'd0;
      stall_cnt_q    <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      pending_rd_q   <= pending_rd_d;
      stall_cnt_q    <= stall_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign pending_rd   = pending_rd_q;
  assign stall_cnt    = stall_cnt_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_load_use_interlock.sv
// Bench for load_use_interlock: directed scenarios plus randomized traffic
// compared against a behavioural model of outstanding loads.
module tb_load_use_interlock;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk;
  logic             rst_n;
  logic [31:0]      D_inst, X_inst;
  logic             D_valid, X_valid;
  logic             dmem_req_valid, dmem_req_ready, dmem_resp_valid, flush;
  logic             stall, pending, protocol_err;
  logic [4:0]       pending_rd;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: a load is either outstanding, in its writeback cycle, or absent.
  bit m_wait, m_wb, m_err;
  int m_rd, m_cnt;

  load_use_interlock #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .D_inst          (D_inst),
    .D_valid         (D_valid),
    .X_inst          (X_inst),
    .X_valid         (X_valid),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .flush           (flush),
    .stall           (stall),
    .pending         (pending),
    .pending_rd      (pending_rd),
    .stall_cnt       (stall_cnt),
    .protocol_err    (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd,
                                     input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit reads_reg(input logic [31:0] inst, input int r);
    if (r == 0) return 1'b0;
    return (reads_rs1(inst[6:0]) && int'(inst[19:15]) == r) ||
           (reads_rs2(inst[6:0]) && int'(inst[24:20]) == r);
  endfunction

  function automatic bit x_is_live_load();
    return X_valid && X_inst[6:0] == 7'b0000011 && X_inst[11:7] != 5'd0;
  endfunction

  function automatic bit model_stall();
    bit dep_mem, dep_x;
    dep_mem = m_wait && reads_reg(D_inst, m_rd);
    dep_x   = x_is_live_load() && reads_reg(D_inst, int'(X_inst[11:7]));
    return D_valid && !flush && (dep_mem || dep_x);
  endfunction

  function automatic logic [31:0] rand_inst(input bit load_bias);
    logic [6:0] op;
    if (load_bias && $urandom_range(0, 1) == 0) op = 7'b0000011;
    else begin
      case ($urandom_range(0, 7))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        5: op = 7'b1100111;
        6: op = 7'b0110111;
        default: op = 7'b1101111;
      endcase
    end
    return mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [31:0] di,
                               input logic xv, input logic [31:0] xi,
                               input logic rqv, input logic rqr,
                               input logic rsp, input logic fl);
    D_valid = dv; D_inst = di; X_valid = xv; X_inst = xi;
    dmem_req_valid = rqv; dmem_req_ready = rqr;
    dmem_resp_valid = rsp; flush = fl;
  endtask

  task automatic settle_check(input string tag);
    #1;
    checkOutput({tag, "_stall"}, 32'(stall), 32'(model_stall()));
  endtask

  task automatic tick(input string tag);
    bit exp_stall, acc;
    exp_stall = model_stall();
    acc = x_is_live_load() && dmem_req_valid && dmem_req_ready && !flush;
    if (m_wait) begin
      if (acc) m_err = 1'b1;
      if (dmem_resp_valid) begin m_wait = 1'b0; m_wb = 1'b1; end
    end else begin
      if (dmem_resp_valid) m_err = 1'b1;
      m_wb = 1'b0;
      if (acc) begin m_wait = 1'b1; m_rd = int'(X_inst[11:7]); end
    end
    if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
    checkOutput({tag, "_pending"}, 32'(pending), 32'(m_wait || m_wb));
    if (m_wait || m_wb) checkOutput({tag, "_prd"}, 32'(pending_rd), 32'(m_rd));
    checkOutput({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    checkOutput({tag, "_err"}, 32'(protocol_err), 32'(m_err));
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    m_wait = 0; m_wb = 0; m_err = 0; m_rd = 0; m_cnt = 0;
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_prd", 32'(pending_rd), 32'd0);
    checkOutput("rst_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_err", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] lw5, add_dep5, lw7, sw7, lui5;
    lw5      = mk(7'b0000011, 5, 1, 0);
    add_dep5 = mk(7'b0110011, 6, 5, 1);
    lw7      = mk(7'b0000011, 7, 2, 0);
    sw7      = mk(7'b0100011, 0, 2, 7);
    lui5     = mk(7'b0110111, 9, 5, 0);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // One-cycle load-use with no memory handshake
    applyStimulus(1, add_dep5, 1, lw5, 0, 0, 0, 0);
    settle_check("lu");
    checkOutput("lu_stall_const", 32'(stall), 32'd1);
    tick("lu");
    checkOutput("lu_cnt_const", 32'(stall_cnt), 32'd1);

    // Load to x0 never creates a dependency
    applyStimulus(1, mk(7'b0110011, 6, 0, 0), 1, mk(7'b0000011, 0, 1, 0), 1, 1, 0, 0);
    settle_check("x0");
    checkOutput("x0_stall_const", 32'(stall), 32'd0);
    tick("x0");

    // Miss on lw x7 with response four cycles after acceptance
    do_reset();
    applyStimulus(0, 0, 1, lw7, 1, 1, 0, 0);
    settle_check("miss_acc");
    tick("miss_acc");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, sw7, 0, 0, 0, 0, (i == 3), 0);
      settle_check("miss_wait");
      checkOutput("miss_wait_stall_const", 32'(stall), 32'd1);
      tick("miss_wait");
    end
    checkOutput("miss_prd_const", 32'(pending_rd), 32'd7);
    applyStimulus(1, sw7, 0, 0, 0, 0, 0, 0);
    settle_check("miss_drain");
    checkOutput("miss_drain_stall_const", 32'(stall), 32'd0);
    checkOutput("miss_drain_pending_const", 32'(pending), 32'd1);
    tick("miss_drain");
    checkOutput("miss_idle_pending_const", 32'(pending), 32'd0);

    // Unused source field matching pending_rd, then flush during WAIT_RESP
    do_reset();
    applyStimulus(0, 0, 1, lw5, 1, 1, 0, 0);
    settle_check("fl_acc");
    tick("fl_acc");
    applyStimulus(1, lui5, 0, 0, 0, 0, 0, 0);
    settle_check("lui");
    checkOutput("lui_stall_const", 32'(stall), 32'd0);
    tick("lui");
    applyStimulus(1, add_dep5, 0, 0, 0, 0, 0, 1);
    settle_check("flush");
    checkOutput("flush_stall_const", 32'(stall), 32'd0);
    tick("flush");
    checkOutput("flush_pending_const", 32'(pending), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    settle_check("fl_resp");
    tick("fl_resp");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    settle_check("fl_drain");
    tick("fl_drain");
    checkOutput("fl_idle_pending_const", 32'(pending), 32'd0);

    // Reset while a load is outstanding; the late response is then stray
    applyStimulus(0, 0, 1, lw7, 1, 1, 0, 0);
    settle_check("rw_acc");
    tick("rw_acc");
    do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    settle_check("rw_resp");
    tick("rw_resp");
    checkOutput("rw_err_const", 32'(protocol_err), 32'd1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, add_dep5, 1, lw5, 0, 0, 0, 0);
      settle_check("sat");
      tick("sat");
    end
    checkOutput("sat_cnt_const", 32'(stall_cnt), 32'd15);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        applyStimulus($urandom_range(0, 7) != 0, rand_inst(1'b0),
                      $urandom_range(0, 3) != 0, rand_inst(1'b1),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0),
                      $urandom_range(0, 9) == 0);
        settle_check("rnd");
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_use_interlock.md
LOAD_USE_INTERLOCK -- requirements
Module: load_use_interlock

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: D_inst  input  32  decode-stage instruction; D_valid  input  1  D_inst is live.
REQ-005 Port: X_inst  input  32  execute-stage instruction; X_valid  input  1  X_inst is live.
REQ-006 Port: dmem_req_valid / dmem_req_ready  input  1 each  data-memory request handshake; a request is accepted when both are high.
REQ-007 Port: dmem_resp_valid  input  1  load data returns this cycle.
REQ-008 Port: flush  input  1  kills the D and X instructions this cycle.
REQ-009 Port: stall  output  1  freezes PC and D; inserts a bubble into X.
REQ-010 Port: pending  output  1, pending_rd  output  5  an outstanding load exists, and its destination register.
REQ-011 Port: stall_cnt  output  CNT_W  saturating count of cycles with stall high.
REQ-012 Port: protocol_err  output  1  sticky flag for an unexpected response.

Function
REQ-013 Decode: opcode = inst[6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
REQ-014 rs1 is used by opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1100111; rs2 is used by 0110011, 0100011 and 1100011; a source equal to x0 never matches.
REQ-015 States: IDLE, WAIT_RESP and DRAIN, held in registers.
REQ-016 Load accepted: X_valid & opcode(X)==0000011 & rd(X)!=0 & dmem_req_valid & dmem_req_ready & !flush.
REQ-017 IDLE -> WAIT_RESP on load accepted; pending_rd <= rd(X).
REQ-018 WAIT_RESP -> DRAIN on dmem_resp_valid.
REQ-019 DRAIN lasts exactly one cycle (the writeback write cycle); it then goes to WAIT_RESP if a load is accepted that cycle, otherwise to IDLE.
REQ-020 A load accepted in WAIT_RESP is excluded by the memory contract (one outstanding load); the block ignores it and sets protocol_err.
REQ-021 pending = 1 in WAIT_RESP and DRAIN; pending_rd holds its value otherwise (don't-care).
REQ-022 stall (combinational) = D_valid & !flush & (hazA | hazB).
REQ-023 hazA: state==WAIT_RESP and a used D source equals pending_rd.
REQ-024 hazB: X_valid and X is a load with rd(X)!=0 matching a used D source (one-cycle load-use).
REQ-025 DRAIN does not stall; writeback forwarding covers that case.
REQ-026 flush does not cancel an accepted load (it is older than any flushed instruction); WAIT_RESP persists through flush.
REQ-027 dmem_resp_valid in IDLE or DRAIN is ignored and sets protocol_err, which stays set until reset.
REQ-028 stall_cnt increments on each cycle with stall=1 and saturates at 2^CNT_W-1 with no wrap.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, pending=0, pending_rd=0, stall_cnt=0 and protocol_err=0; stall then depends only on hazB.
REQ-030 Reset asserted mid-WAIT_RESP discards the outstanding load with no further response expected; a later response sets protocol_err.

Structure
REQ-031 Opcode constants, the state encoding and CNT_W's default belong in shared package riscv_pkg.
REQ-032 Sub-module inst_src_decode (opcode -> rs1_used, rs2_used, is_load) is instantiated twice, once for D and once for X.

Verification
REQ-033 Load-use: X = lw x5, D = add x6,x5,x1, no handshake -> stall=1 for 1 cycle; stall_cnt=1.
REQ-034 Miss: lw x7 accepted, response 4 cycles later, D = sw x7 -> stall high through WAIT_RESP, low in DRAIN; pending_rd=7.
REQ-035 x0 and unused sources: X = lw x0, or D = lui using bits[19:15]=5 with pending_rd=5 -> stall=0.
REQ-036 Flush during WAIT_RESP: flush=1 with a dependent D -> stall=0 that cycle; state stays WAIT_RESP; response -> DRAIN -> IDLE.
REQ-037 Reset mid-WAIT_RESP: pull rst_n low -> pending=0 immediately; a later dmem_resp_valid -> protocol_err=1.
REQ-038 Saturation: CNT_W=4 with 20 continuous stall cycles -> stall_cnt holds at 15.
